// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N counter family.
// Also intended for future loadable counters that need the same load clamping.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    // Limit a load value to the top of the count range (mod-1).
    function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] mod);
        return (d > mod - 32'd1) ? mod - 32'd1 : d;
    endfunction

endpackage

// File: rtl/counter_mod_if.sv
// Control and status bundle of one counter stage.
// The master side drives the controls; the counter (slave) drives the status outputs.
interface counter_mod_if #(
    parameter int W = 3
);
    import counter_pkg::*;

    logic          enb;
    logic          up;
    logic          ld;
    logic [W-1:0]  d;
    cnt_mode_t     mode;
    logic [W-1:0]  q;
    logic          tc;
    logic          co;
    logic          ovf;

    modport master (output enb, up, ld, d, mode, input q, tc, co, ovf);
    modport slave  (input enb, up, ld, d, mode, output q, tc, co, ovf);

endinterface

// File: rtl/counter_next.sv
// Combinational next-count and boundary detection for a modulo-MOD counter.
// The arithmetic is done one bit wider so that non-power-of-2 moduli never depend on natural rollover.
module counter_next
    import counter_pkg::*;
#(
    parameter int W   = 3,
    parameter int MOD = 2**W
) (
    input  logic [W-1:0] q,
    input  logic         up,
    input  cnt_mode_t    mode,
    output logic [W-1:0] q_nxt,
    output logic         at_bound
);

    localparam logic [W:0] LAST = (W+1)'(MOD - 1);

    logic [W:0] q_ext;
    logic [W:0] inc;
    logic [W:0] dec;

    assign q_ext = {1'b0, q};
    assign inc   = q_ext + 1'b1;
    assign dec   = q_ext - 1'b1;

    // Up: stepping past LAST is the boundary. Down: a borrow into the extra bit means q was 0.
    always_comb begin
        at_bound = up ? (inc > LAST) : dec[W];
        q_nxt    = up ? inc[W-1:0] : dec[W-1:0];
        if (at_bound) begin
            if (mode == CNT_WRAP) begin
                q_nxt = up ? '0 : LAST[W-1:0];
            end else begin
                q_nxt = q;
            end
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Modulo-MOD up/down counter with load, wrap/saturate, terminal count, cascade carry and sticky overflow.
// The always_ff only selects between reset, load, step and hold; the step itself comes from counter_next.
module counter_mod
    import counter_pkg::*;
#(
    parameter int W   = 3,
    parameter int MOD = 2**W
) (
    input  logic          clk,
    input  logic          rst,
    counter_mod_if.slave  bus
);

    generate
        if (MOD < 2 || MOD > 2**W) begin : g_bad_mod
            $error("counter_mod: MOD must satisfy 2 <= MOD <= 2**W");
        end
    endgenerate

    logic [W-1:0] q_reg;
    logic         ovf_reg;
    logic [W-1:0] step_val;
    logic [W-1:0] load_val;
    logic         at_bound;

    counter_next #(
        .W   (W),
        .MOD (MOD)
    ) u_next (
        .q        (q_reg),
        .up       (bus.up),
        .mode     (bus.mode),
        .q_nxt    (step_val),
        .at_bound (at_bound)
    );

    assign load_val = W'(clamp_load(32'(bus.d), 32'(MOD)));

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= '0;
            ovf_reg <= 1'b0;
        end else if (bus.ld) begin
            q_reg   <= load_val;
            ovf_reg <= 1'b0;
        end else if (bus.enb) begin
            q_reg <= step_val;
            if (at_bound) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign bus.q   = q_reg;
    assign bus.tc  = at_bound;
    assign bus.co  = bus.enb && at_bound && !bus.ld && !rst;
    assign bus.ovf = ovf_reg;

    // The count must stay inside 0..MOD-1 whenever the counter is out of reset.
    assert property (@(posedge clk) disable iff (rst) ({1'b0, q_reg} < (W+1)'(MOD)));

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: directed scenarios plus randomized traffic against a behavioural model.
// Also covers a two-stage decimal cascade and a power-of-2 instance.
module tb_counter_mod;
    import counter_pkg::*;

    localparam int MA = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_c;
    logic rst_p;

    counter_mod_if #(.W(4)) a_if ();
    counter_mod_if #(.W(4)) u_if ();
    counter_mod_if #(.W(4)) t_if ();
    counter_mod_if #(.W(3)) p_if ();

    counter_mod #(.W(4), .MOD(10)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    counter_mod #(.W(4), .MOD(10)) dut_u (.clk(clk), .rst(rst_c), .bus(u_if.slave));
    counter_mod #(.W(4), .MOD(10)) dut_t (.clk(clk), .rst(rst_c), .bus(t_if.slave));
    counter_mod #(.W(3), .MOD(8))  dut_p (.clk(clk), .rst(rst_p), .bus(p_if.slave));

    assign t_if.enb = u_if.co;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state for dut_a
    int m_q    = 0;
    bit m_ovf  = 1'b0;
    int nxt_q;
    bit nxt_ovf;
    bit exp_tc;
    bit exp_co;

    // Apply one cycle of inputs to dut_a, predict its outputs, and wait to the sampling edge.
    task automatic set_a(input bit r, input bit l, input int dv, input bit e, input bit u, input bit m);
        rst_a     = r;
        a_if.ld   = l;
        a_if.d    = 4'(dv);
        a_if.enb  = e;
        a_if.up   = u;
        a_if.mode = cnt_mode_t'(m);
        exp_tc  = u ? (m_q == MA - 1) : (m_q == 0);
        exp_co  = e && exp_tc && !l && !r;
        nxt_q   = m_q;
        nxt_ovf = m_ovf;
        if (r) begin
            nxt_q   = 0;
            nxt_ovf = 1'b0;
        end else if (l) begin
            nxt_q   = (dv > MA - 1) ? MA - 1 : dv;
            nxt_ovf = 1'b0;
        end else if (e) begin
            if (exp_tc) nxt_ovf = 1'b1;
            if (!(exp_tc && m)) nxt_q = u ? (m_q + 1) % MA : (m_q + MA - 1) % MA;
        end
        @(negedge clk);
    endtask

    task automatic tick_a();
        @(posedge clk);
        #1;
        m_q   = nxt_q;
        m_ovf = nxt_ovf;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_a(1'b1, 1'b0, 0, 1'b1, (i == 1), 1'b0);
            checks += 2;
            if (a_if.tc !== exp_tc) begin fails++; $display("FAIL reset_tc cyc %0d: got %b want %b", i, a_if.tc, exp_tc); end
            if (a_if.co !== 1'b0) begin fails++; $display("FAIL reset_co cyc %0d: got %b want 0", i, a_if.co); end
            tick_a();
            checks += 2;
            if (a_if.q !== 4'd0) begin fails++; $display("FAIL reset_q cyc %0d: got %0d want 0", i, a_if.q); end
            if (a_if.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf cyc %0d: got %b want 0", i, a_if.ovf); end
        end
    endtask

    task automatic test_up_wrap();
        for (int i = 0; i < 12; i++) begin
            set_a(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
            checks += 2;
            if (a_if.tc !== exp_tc) begin fails++; $display("FAIL up_tc cyc %0d: got %b want %b", i, a_if.tc, exp_tc); end
            if (a_if.co !== exp_co) begin fails++; $display("FAIL up_co cyc %0d: got %b want %b", i, a_if.co, exp_co); end
            tick_a();
            checks += 2;
            if (a_if.q !== 4'(m_q)) begin fails++; $display("FAIL up_q cyc %0d: got %0d want %0d", i, a_if.q, m_q); end
            if (a_if.ovf !== m_ovf) begin fails++; $display("FAIL up_ovf cyc %0d: got %b want %b", i, a_if.ovf, m_ovf); end
        end
        checks += 1;
        if (a_if.q !== 4'd2 || a_if.ovf !== 1'b1) begin
            fails++; $display("FAIL up_end: got q=%0d ovf=%b want q=2 ovf=1", a_if.q, a_if.ovf);
        end
    endtask

    task automatic test_down_wrap();
        for (int i = 0; i < 5; i++) begin
            set_a(1'b0, (i == 0), 2, 1'b1, 1'b0, 1'b0);
            checks += 2;
            if (a_if.tc !== exp_tc) begin fails++; $display("FAIL down_tc cyc %0d: got %b want %b", i, a_if.tc, exp_tc); end
            if (a_if.co !== exp_co) begin fails++; $display("FAIL down_co cyc %0d: got %b want %b", i, a_if.co, exp_co); end
            tick_a();
            checks += 2;
            if (a_if.q !== 4'(m_q)) begin fails++; $display("FAIL down_q cyc %0d: got %0d want %0d", i, a_if.q, m_q); end
            if (a_if.ovf !== m_ovf) begin fails++; $display("FAIL down_ovf cyc %0d: got %b want %b", i, a_if.ovf, m_ovf); end
        end
    endtask

    task automatic test_sat();
        for (int i = 0; i < 7; i++) begin
            set_a(1'b0, (i == 0), 8, 1'b1, (i < 5), 1'b1);
            checks += 2;
            if (a_if.tc !== exp_tc) begin fails++; $display("FAIL sat_tc cyc %0d: got %b want %b", i, a_if.tc, exp_tc); end
            if (a_if.co !== exp_co) begin fails++; $display("FAIL sat_co cyc %0d: got %b want %b", i, a_if.co, exp_co); end
            tick_a();
            checks += 2;
            if (a_if.q !== 4'(m_q)) begin fails++; $display("FAIL sat_q cyc %0d: got %0d want %0d", i, a_if.q, m_q); end
            if (a_if.ovf !== m_ovf) begin fails++; $display("FAIL sat_ovf cyc %0d: got %b want %b", i, a_if.ovf, m_ovf); end
        end
    endtask

    task automatic test_load_clamp();
        set_a(1'b0, 1'b1, 14, 1'b1, 1'b1, 1'b0);
        checks += 1;
        if (a_if.co !== 1'b0) begin fails++; $display("FAIL clamp_co: got %b want 0", a_if.co); end
        tick_a();
        checks += 2;
        if (a_if.q !== 4'd9) begin fails++; $display("FAIL clamp_q: got %0d want 9", a_if.q); end
        if (a_if.ovf !== 1'b0) begin fails++; $display("FAIL clamp_ovf: got %b want 0", a_if.ovf); end
        set_a(1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0);
        checks += 1;
        if (a_if.co !== 1'b0) begin fails++; $display("FAIL rstld_co: got %b want 0", a_if.co); end
        tick_a();
        checks += 1;
        if (a_if.q !== 4'd0) begin fails++; $display("FAIL rstld_q: got %0d want 0", a_if.q); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_a(($urandom_range(0, 30) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks += 2;
            if (a_if.tc !== exp_tc) begin fails++; $display("FAIL rand_tc cyc %0d: got %b want %b", i, a_if.tc, exp_tc); end
            if (a_if.co !== exp_co) begin fails++; $display("FAIL rand_co cyc %0d: got %b want %b", i, a_if.co, exp_co); end
            tick_a();
            checks += 2;
            if (a_if.q !== 4'(m_q)) begin fails++; $display("FAIL rand_q cyc %0d: got %0d want %0d", i, a_if.q, m_q); end
            if (a_if.ovf !== m_ovf) begin fails++; $display("FAIL rand_ovf cyc %0d: got %b want %b", i, a_if.ovf, m_ovf); end
        end
    endtask

    task automatic test_cascade();
        @(posedge clk);
        #1;
        rst_c    = 1'b0;
        u_if.enb = 1'b1;
        for (int c = 1; c <= 105; c++) begin
            @(posedge clk);
            #1;
            checks += 2;
            if (u_if.q !== 4'(c % 10)) begin fails++; $display("FAIL casc_units cyc %0d: got %0d want %0d", c, u_if.q, c % 10); end
            if (t_if.q !== 4'((c / 10) % 10)) begin fails++; $display("FAIL casc_tens cyc %0d: got %0d want %0d", c, t_if.q, (c / 10) % 10); end
        end
        u_if.enb = 1'b0;
        checks += 1;
        if (t_if.ovf !== 1'b1) begin fails++; $display("FAIL casc_tens_ovf: got %b want 1", t_if.ovf); end
    endtask

    task automatic test_pow2();
        @(posedge clk);
        #1;
        rst_p    = 1'b0;
        p_if.enb = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            checks += 1;
            if (p_if.co !== (k == 8)) begin fails++; $display("FAIL p2_co step %0d: got %b want %b", k, p_if.co, (k == 8)); end
            @(posedge clk);
            #1;
            checks += 1;
            if (p_if.q !== 3'(k % 8)) begin fails++; $display("FAIL p2_q step %0d: got %0d want %0d", k, p_if.q, k % 8); end
        end
        checks += 1;
        if (p_if.ovf !== 1'b1) begin fails++; $display("FAIL p2_ovf_wrap: got %b want 1", p_if.ovf); end
        rst_p = 1'b1;
        @(negedge clk);
        checks += 1;
        if (p_if.co !== 1'b0) begin fails++; $display("FAIL p2_rst_co_mid: got %b want 0", p_if.co); end
        @(posedge clk);
        #1;
        checks += 2;
        if (p_if.q !== 3'd0) begin fails++; $display("FAIL p2_rst_q: got %0d want 0", p_if.q); end
        if (p_if.ovf !== 1'b0) begin fails++; $display("FAIL p2_rst_ovf: got %b want 0", p_if.ovf); end
        rst_p = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_p = 1'b1;
        @(negedge clk);
        checks += 2;
        if (p_if.tc !== 1'b1) begin fails++; $display("FAIL p2_rst_tc_top: got %b want 1", p_if.tc); end
        if (p_if.co !== 1'b0) begin fails++; $display("FAIL p2_rst_co_top: got %b want 0", p_if.co); end
        @(posedge clk);
        #1;
        checks += 1;
        if (p_if.q !== 3'd0) begin fails++; $display("FAIL p2_rst_q_top: got %0d want 0", p_if.q); end
        rst_p    = 1'b0;
        p_if.enb = 1'b0;
    endtask

    initial begin
        rst_c = 1'b1;
        rst_p = 1'b1;
        u_if.enb = 1'b0; u_if.up = 1'b1; u_if.ld = 1'b0; u_if.d = '0; u_if.mode = CNT_WRAP;
        t_if.up = 1'b1; t_if.ld = 1'b0; t_if.d = '0; t_if.mode = CNT_WRAP;
        p_if.enb = 1'b0; p_if.up = 1'b1; p_if.ld = 1'b0; p_if.d = '0; p_if.mode = CNT_WRAP;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_sat();
        test_load_clamp();
        test_random();
        test_cascade();
        test_pow2();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo-N binary counter: the general-purpose successor to the basic enable/sync-reset counter. Adds count direction, parallel load, wrap or saturate at the modulus boundary, a terminal-count indicator, a cascade carry output and a sticky overflow flag. Used for BCD digits, timer prescalers and multi-digit cascaded counters. Chained instances share `clk`/`rst`, with one stage's `co` driving the next stage's `enb`.

## Interface
- `W`, 3: count width in bits.
- `MOD`, 2**W: modulus. Count range is 0..MOD-1. Legal range is 2 ≤ MOD ≤ 2**W; elaboration-time assertion.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `enb` in 1: count enable; one step per enabled cycle.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `ld` in 1: parallel load strobe.
- `d` in W: load value.
- `mode` in 1: `cnt_mode_t`; WRAP (0) or SAT (1).
- `q` out W: registered count.
- `tc` out 1: terminal count, combinational from `q` and `up`.
- `co` out 1: cascade carry/borrow, combinational.
- `ovf` out 1: sticky boundary-event flag, registered.

## Operation
- Priority order per cycle is `rst` > `ld` > `enb` > hold.
- `rst`:
  - Sets `q` to 0 and `ovf` to 0.
  - Reset values of outputs: `q`=0, `ovf`=0. `tc`=1 if `up`=0, else (MOD-1==0)=0. `co` follows.
- `ld`:
  - Sets `q` to `d` when `d` ≤ MOD-1.
  - When `d` > MOD-1, sets `q` to MOD-1 (clamp).
  - Clears `ovf`.
  - `enb` is ignored in a load cycle; no step is taken.
- `enb`, count:
  - `up`=1 and `q`<MOD-1: `q`+1.
  - `up`=0 and `q`>0: `q`-1.
- `enb`, boundary (`tc`=1):
  - WRAP: up goes MOD-1→0; down goes 0→MOD-1. Sets `ovf`.
  - SAT: `q` holds. Sets `ovf`.
- `tc` = (`up` && `q`==MOD-1) || (!`up` && `q`==0).
- `co` = `enb` && `tc` && !`ld` && !`rst`.
  - Asserted in both modes.
  - In SAT, `co` asserting on every enabled cycle at the boundary is the required behaviour.
- `ovf`:
  - Set on any enabled boundary step.
  - Held until `rst` or `ld`.
  - A boundary step and `ld` in the same cycle: `ld` wins, `ovf`=0.
- Direction or mode may change on any cycle. The new value takes effect on that cycle's edge; no internal state depends on the previous direction.
- Arithmetic:
  - Next-value computation is done in W+1 bits, then compared against MOD-1.
  - No reliance on natural 2**W wrap, since MOD may be non-power-of-2.
- `q` never holds a value ≥ MOD after reset. This is checked by assertion.

## Timing
- `q` and `ovf` update one cycle after the qualifying input. Latency 1.
- `tc` and `co` are zero-latency combinational outputs from current `q` and inputs. No registered pipeline.
- Cascade: stage k+1 `enb` = stage k `co`. The whole chain steps in the same edge; no ripple delay in cycles.
- `rst` mid-count takes effect at the next edge regardless of `enb`/`ld`.
- `co` is forced low during the `rst` cycle.

## Structure
- Package `counter_pkg` holds:
  - `typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_t;`
  - A function `clamp_load(d, MOD)` for shared use by future loadable counters.
- One sub-module, `counter_next`: purely combinational next-state/boundary logic.
  - Inputs: `q`, `up`, `mode`.
  - Outputs: `q_nxt`, `at_bound`.
  - Keeps the `always_ff` in `counter_mod` to register selection only.
- Estimated size: 150–200 lines including assertions.

## Test plan
Configuration W=4, MOD=10 unless noted.

1. Reset and up-count.
   - Stimulus: assert `rst` 2 cycles, then `enb`=1, `up`=1, WRAP for 12 cycles.
   - Required response: `q` runs 0..9, 0, 1. `tc`=1 only at 9. `co` pulses one cycle at 9. `ovf` becomes 1 after the 9→0 step.
2. Down-count WRAP.
   - Stimulus: load `d`=2, then down-count 4 cycles.
   - Required response: `q`=2,1,0,9,8. `co` high while `q`=0. `ovf`=0 until the 0→9 step.
3. SAT mode.
   - Stimulus: load 8, up-count 4 cycles, then `up`=0 for 2 cycles.
   - Required response: `q`=8,9,9,9,9,8,7. `co` high for 3 enabled cycles at 9. `ovf`=1 and stays 1.
4. Load clamp and priority.
   - Stimulus: `ld`=1, `d`=14, `enb`=1.
   - Required response: `q`=9, `ovf`=0, `co`=0 that cycle.
   - Stimulus: `rst`=1 with `ld`=1, `d`=5.
   - Required response: `q`=0.
5. Cascade.
   - Stimulus: two instances, MOD=10, units `co` → tens `enb`; enable units 105 cycles.
   - Required response: tens=0, units=5 (00→99→wrap→05). Tens `ovf`=1.
6. Power-of-2 and reset mid-count.
   - Stimulus: W=3, MOD=8; up-count to 5, then `rst`=1 for 1 cycle while `enb`=1.
   - Required response: `q`=0 next edge, `ovf`=0, `co`=0 during the `rst` cycle.
